// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Size encodings and FSM state type.
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the load/store unit.
// Store mask/shift generation and load extraction/extension.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [7:0]  o_mask,
    output logic [63:0] o_sdata,
    output logic        o_misaligned,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_base;
    logic [2:0]  w_nbytes;
    logic [63:0] w_shifted;
    logic [4:0]  w_shamt;

    // Base byte mask and byte count for the access size
    always_comb begin
        w_base   = 8'h00;
        w_nbytes = 3'd0;
        unique case (i_size)
            SZ_B: begin w_base = 8'h01; w_nbytes = 3'd1; end
            SZ_H: begin w_base = 8'h03; w_nbytes = 3'd2; end
            SZ_W: begin w_base = 8'h0F; w_nbytes = 3'd4; end
            default: begin w_base = 8'h00; w_nbytes = 3'd0; end
        endcase
    end

    assign w_shamt      = {i_offset, 3'b000};
    assign o_mask       = w_base << i_offset;
    assign o_sdata      = {32'b0, i_wdata} << w_shamt;
    assign o_misaligned = ({1'b0, i_offset} + w_nbytes) > 3'd4;
    assign w_shifted    = {i_hi, i_lo} >> w_shamt;

    // Pick the low bytes of the shifted pair and extend them
    always_comb begin
        o_ldata = w_shifted[31:0];
        unique case (i_size)
            SZ_B: o_ldata = {{24{~i_unsigned & w_shifted[7]}},
                             w_shifted[7:0]};
            SZ_H: o_ldata = {{16{~i_unsigned & w_shifted[15]}},
                             w_shifted[15:0]};
            default: o_ldata = w_shifted[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of the data RAM.
// Splits misaligned accesses into two word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int RD_W     = 5
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic [31:0]     dmem_addr_o,
    output logic [31:0]     dmem_wr_data_o,
    output logic [0:3]      dmem_wr_strb_o,
    output logic            dmem_wr_en_o,
    input  logic [31:0]     dmem_rd_data_i,
    output logic            resp_valid_o,
    output logic [31:0]     resp_data_o,
    output logic [RD_W-1:0] resp_rd_o,
    output logic            resp_err_o
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_lo_buf;
    logic [31:0]     r_addr;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic            r_we;
    logic [RD_W-1:0] r_rd;
    logic [3:0]      r_strb_hi;
    logic [31:0]     r_wdata_hi;
    logic            r_resp_valid;
    logic [31:0]     r_resp_data;
    logic [RD_W-1:0] r_resp_rd;
    logic            r_resp_err;

    logic            w_second;
    logic [1:0]      w_size;
    logic [1:0]      w_offset;
    logic            w_unsigned;
    logic [31:0]     w_lo;
    logic [31:0]     w_hi;
    logic [7:0]      w_mask;
    logic [63:0]     w_sdata;
    logic            w_misaligned;
    logic [31:0]     w_ldata;
    logic            w_accept;
    logic            w_illegal;
    logic            w_split;
    logic [3:0]      w_strb4;

    assign w_second   = (r_state == SECOND);
    assign w_size     = w_second ? r_size : req_size_i;
    assign w_offset   = w_second ? r_addr[1:0] : req_addr_i[1:0];
    assign w_unsigned = w_second ? r_unsigned : req_unsigned_i;
    assign w_lo       = w_second ? r_lo_buf : dmem_rd_data_i;
    assign w_hi       = w_second ? dmem_rd_data_i : 32'b0;

    lsu_byte_lane u_lane (
        .i_size       (w_size),
        .i_offset     (w_offset),
        .i_unsigned   (w_unsigned),
        .i_wdata      (req_wdata_i),
        .i_lo         (w_lo),
        .i_hi         (w_hi),
        .o_mask       (w_mask),
        .o_sdata      (w_sdata),
        .o_misaligned (w_misaligned),
        .o_ldata      (w_ldata)
    );

    assign req_ready_o = ~w_second;
    assign w_accept    = req_valid_i & ~w_second;
    assign w_illegal   = (req_size_i == SZ_ILL)
                       | (w_misaligned & ~SPLIT_EN);
    assign w_split     = w_misaligned & SPLIT_EN;

    assign dmem_wr_strb_o = {w_strb4[0], w_strb4[1],
                             w_strb4[2], w_strb4[3]};

    // Next state and RAM-side drive for the current phase
    always_comb begin
        w_state_nxt    = r_state;
        dmem_addr_o    = {req_addr_i[31:2], 2'b00};
        w_strb4        = w_mask[3:0];
        dmem_wr_data_o = w_sdata[31:0];
        dmem_wr_en_o   = w_accept & req_we_i & ~w_illegal;
        unique case (r_state)
            IDLE: begin
                if (w_accept & ~w_illegal & w_split)
                    w_state_nxt = SECOND;
            end
            SECOND: begin
                dmem_addr_o    = {r_addr[31:2], 2'b00} + 32'd4;
                w_strb4        = r_strb_hi;
                dmem_wr_data_o = r_wdata_hi;
                dmem_wr_en_o   = r_we;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (reset)
            dmem_wr_en_o = 1'b0;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Capture first word and request fields of a split access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo_buf   <= '0;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_strb_hi  <= '0;
            r_wdata_hi <= '0;
        end else if (w_accept & ~w_illegal & w_split) begin
            r_lo_buf   <= dmem_rd_data_i;
            r_addr     <= req_addr_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_we       <= req_we_i;
            r_rd       <= req_rd_i;
            r_strb_hi  <= w_mask[7:4];
            r_wdata_hi <= w_sdata[63:32];
        end
    end

    // Register the completed access towards writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_second) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= r_we ? 32'b0 : w_ldata;
                r_resp_rd    <= r_rd;
                r_resp_err   <= 1'b0;
            end else if (w_accept & w_illegal) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= 32'b0;
                r_resp_rd    <= req_rd_i;
                r_resp_err   <= 1'b1;
            end else if (w_accept & ~w_split) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= req_we_i ? 32'b0 : w_ldata;
                r_resp_rd    <= req_rd_i;
                r_resp_err   <= 1'b0;
            end
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign resp_rd_o    = r_resp_rd;
    assign resp_err_o   = r_resp_err;

endmodule
